// File: rtl/usb_tx_arbiter.sv
// Packet-atomic AXI4-Stream arbiter sharing the USB packet-encoder input between the
// handshake generator, EP0 and bulk IN pipes, with a programmable inter-packet gap.
module usb_tx_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int CBITS      = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             hsk_tvalid_i,
    output logic             hsk_tready_o,
    input  logic             hsk_tlast_i,
    input  logic [7:0]       hsk_tdata_i,
    input  logic             ctl_tvalid_i,
    output logic             ctl_tready_o,
    input  logic             ctl_tlast_i,
    input  logic [7:0]       ctl_tdata_i,
    input  logic             blk_tvalid_i,
    output logic             blk_tready_o,
    input  logic             blk_tlast_i,
    input  logic [7:0]       blk_tdata_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [7:0]       m_tdata_o,
    output logic [1:0]       grant_o,
    output logic             busy_o,
    output logic             len_valid_o,
    output logic [CBITS-1:0] len_o
);
    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_HSK  = 2'd1;
    localparam logic [1:0] G_CTL  = 2'd2;
    localparam logic [1:0] G_BLK  = 2'd3;
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             rr_q, rr_d;
    logic [3:0]       gap_q, gap_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] len_q, len_d;
    logic             len_valid_q, len_valid_d;
    logic             beat;

    function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] v);
        return (v == {CBITS{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // Combinational pass-through of the granted source; nothing is forwarded without a grant.
    always_comb begin
        m_tvalid_o   = 1'b0;
        m_tlast_o    = 1'b0;
        m_tdata_o    = 8'd0;
        hsk_tready_o = 1'b0;
        ctl_tready_o = 1'b0;
        blk_tready_o = 1'b0;
        unique case (grant_q)
            G_HSK: begin
                m_tvalid_o   = hsk_tvalid_i;
                m_tlast_o    = hsk_tlast_i;
                m_tdata_o    = hsk_tdata_i;
                hsk_tready_o = m_tready_i;
            end
            G_CTL: begin
                m_tvalid_o   = ctl_tvalid_i;
                m_tlast_o    = ctl_tlast_i;
                m_tdata_o    = ctl_tdata_i;
                ctl_tready_o = m_tready_i;
            end
            G_BLK: begin
                m_tvalid_o   = blk_tvalid_i;
                m_tlast_o    = blk_tlast_i;
                m_tdata_o    = blk_tdata_i;
                blk_tready_o = m_tready_i;
            end
            default: ;
        endcase
    end

    assign beat = m_tvalid_o && m_tready_i;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        gap_d       = gap_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        len_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i && (hsk_tvalid_i || ctl_tvalid_i || blk_tvalid_i)) begin
                    state_d = XFER;
                    if (hsk_tvalid_i)
                        grant_d = G_HSK;
                    else if (ctl_tvalid_i && (!blk_tvalid_i || !rr_q))
                        grant_d = G_CTL;
                    else
                        grant_d = G_BLK;
                end
            end
            XFER: begin
                if (beat) begin
                    if (m_tlast_o) begin
                        len_d       = sat_inc(cnt_q);
                        len_valid_d = 1'b1;
                        cnt_d       = '0;
                        // HSK packets do not disturb the CTL/BLK fairness pointer.
                        if (grant_q == G_CTL)
                            rr_d = 1'b1;
                        else if (grant_q == G_BLK)
                            rr_d = 1'b0;
                        grant_d = G_NONE;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'd0)
                    state_d = IDLE;
                else
                    gap_d = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= G_NONE;
            rr_q        <= 1'b0;
            gap_q       <= 4'd0;
            cnt_q       <= '0;
            len_q       <= '0;
            len_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            len_valid_q <= len_valid_d;
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign len_valid_o = len_valid_q;
    assign len_o       = len_q;
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: queue-driven sources, a cycle-level arbitration model and
// per-scenario tasks; a second instance exercises the zero-gap configuration.
module tb_usb_tx_arbiter;
    localparam int GAP    = 4;
    localparam int CB     = 11;
    localparam int MAXLEN = (1 << CB) - 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n = 1'b0, enable_i = 1'b1;
    logic hsk_tvalid_i = 0, hsk_tlast_i = 0, ctl_tvalid_i = 0, ctl_tlast_i = 0;
    logic blk_tvalid_i = 0, blk_tlast_i = 0, m_tready_i = 0;
    logic [7:0] hsk_tdata_i = 0, ctl_tdata_i = 0, blk_tdata_i = 0;
    logic hsk_tready_o, ctl_tready_o, blk_tready_o, m_tvalid_o, m_tlast_o, busy_o, len_valid_o;
    logic [7:0] m_tdata_o;
    logic [1:0] grant_o;
    logic [CB-1:0] len_o;

    logic z_enable_i = 1'b1, z_hsk_tvalid_i = 0, z_hsk_tlast_i = 0, z_m_tready_i = 1'b1;
    logic z_ctl_tvalid_i = 0, z_ctl_tlast_i = 0, z_blk_tvalid_i = 0, z_blk_tlast_i = 0;
    logic [7:0] z_hsk_tdata_i = 0, z_ctl_tdata_i = 0, z_blk_tdata_i = 0;
    logic z_hsk_tready_o, z_ctl_tready_o, z_blk_tready_o, z_m_tvalid_o, z_m_tlast_o, z_busy_o, z_len_valid_o;
    logic [7:0] z_m_tdata_o;
    logic [1:0] z_grant_o;
    logic [CB-1:0] z_len_o;

    usb_tx_arbiter #(.GAP_CYCLES(GAP), .CBITS(CB)) dut (
        .clock(clock), .reset_n(reset_n), .enable_i(enable_i),
        .hsk_tvalid_i(hsk_tvalid_i), .hsk_tready_o(hsk_tready_o), .hsk_tlast_i(hsk_tlast_i), .hsk_tdata_i(hsk_tdata_i),
        .ctl_tvalid_i(ctl_tvalid_i), .ctl_tready_o(ctl_tready_o), .ctl_tlast_i(ctl_tlast_i), .ctl_tdata_i(ctl_tdata_i),
        .blk_tvalid_i(blk_tvalid_i), .blk_tready_o(blk_tready_o), .blk_tlast_i(blk_tlast_i), .blk_tdata_i(blk_tdata_i),
        .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o), .m_tdata_o(m_tdata_o),
        .grant_o(grant_o), .busy_o(busy_o), .len_valid_o(len_valid_o), .len_o(len_o)
    );

    usb_tx_arbiter #(.GAP_CYCLES(0), .CBITS(CB)) dut_zero (
        .clock(clock), .reset_n(reset_n), .enable_i(z_enable_i),
        .hsk_tvalid_i(z_hsk_tvalid_i), .hsk_tready_o(z_hsk_tready_o), .hsk_tlast_i(z_hsk_tlast_i), .hsk_tdata_i(z_hsk_tdata_i),
        .ctl_tvalid_i(z_ctl_tvalid_i), .ctl_tready_o(z_ctl_tready_o), .ctl_tlast_i(z_ctl_tlast_i), .ctl_tdata_i(z_ctl_tdata_i),
        .blk_tvalid_i(z_blk_tvalid_i), .blk_tready_o(z_blk_tready_o), .blk_tlast_i(z_blk_tlast_i), .blk_tdata_i(z_blk_tdata_i),
        .m_tvalid_o(z_m_tvalid_o), .m_tready_i(z_m_tready_i), .m_tlast_o(z_m_tlast_o), .m_tdata_o(z_m_tdata_o),
        .grant_o(z_grant_o), .busy_o(z_busy_o), .len_valid_o(z_len_valid_o), .len_o(z_len_o)
    );

    int n_checks = 0, n_errors = 0, cyc = 0;
    int rdy_mode = 0, rdy_phase = 0, beat_cnt = 0, busy_fall_cyc = -1;
    logic [8:0] hsk_q[$], ctl_q[$], blk_q[$];   // what each source still has to send
    logic [8:0] hsk_e[$], ctl_e[$], blk_e[$];   // what the encoder must still receive
    int grant_log[$], grant_cyc[$], len_log[$], last_log[$];
    int prev_grant = 0;
    logic prev_busy = 1'b0;

    // Reference model state: current grant, remaining gap cycles, fairness pointer, beat count.
    logic [1:0] m_grant = 0;
    int m_gap = 0, m_cnt = 0, m_len = 0;
    logic m_rr = 0, m_lv = 0;

    task automatic add_pkt(input int src, input int len, input logic [7:0] base, input bit rnd);
        logic [8:0] b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), rnd ? 8'($urandom) : 8'(base + i)};
            case (src)
                1: begin hsk_q.push_back(b); hsk_e.push_back(b); end
                2: begin ctl_q.push_back(b); ctl_e.push_back(b); end
                3: begin blk_q.push_back(b); blk_e.push_back(b); end
                default: ;
            endcase
        end
    endtask

    task automatic clear_logs();
        grant_log.delete(); grant_cyc.delete(); len_log.delete(); last_log.delete();
        busy_fall_cyc = -1;
    endtask

    task automatic step();
        logic ev, el;
        logic [7:0] ed;
        logic [2:0] er;
        logic [8:0] eb;
        bit have;
        @(negedge clock);
        hsk_tvalid_i = (hsk_q.size() != 0);
        {hsk_tlast_i, hsk_tdata_i} = hsk_tvalid_i ? hsk_q[0] : 9'd0;
        ctl_tvalid_i = (ctl_q.size() != 0);
        {ctl_tlast_i, ctl_tdata_i} = ctl_tvalid_i ? ctl_q[0] : 9'd0;
        blk_tvalid_i = (blk_q.size() != 0);
        {blk_tlast_i, blk_tdata_i} = blk_tvalid_i ? blk_q[0] : 9'd0;
        case (rdy_mode)
            0: m_tready_i = 1'b1;
            1: m_tready_i = 1'($urandom_range(0, 1));
            default: begin m_tready_i = (rdy_phase % 3 == 0); rdy_phase++; end
        endcase
        #1;
        cyc++;
        ev = 0; el = 0; ed = 0; er = 3'b000;
        case (m_grant)
            2'd1: begin ev = hsk_tvalid_i; el = hsk_tlast_i; ed = hsk_tdata_i; er = {m_tready_i, 2'b00}; end
            2'd2: begin ev = ctl_tvalid_i; el = ctl_tlast_i; ed = ctl_tdata_i; er = {1'b0, m_tready_i, 1'b0}; end
            2'd3: begin ev = blk_tvalid_i; el = blk_tlast_i; ed = blk_tdata_i; er = {2'b00, m_tready_i}; end
            default: ;
        endcase
        if (reset_n) begin
            n_checks++;
            if (grant_o !== m_grant) begin
                n_errors++; $display("FAIL grant: got %0d want %0d (cycle %0d)", grant_o, m_grant, cyc);
            end
            n_checks++;
            if (busy_o !== (m_grant != 0 || m_gap != 0)) begin
                n_errors++; $display("FAIL busy: got %b want %b (cycle %0d)", busy_o, (m_grant != 0 || m_gap != 0), cyc);
            end
            n_checks++;
            if (len_valid_o !== m_lv) begin
                n_errors++; $display("FAIL len_valid: got %b want %b (cycle %0d)", len_valid_o, m_lv, cyc);
            end
            if (m_lv) begin
                n_checks++;
                if (int'(len_o) !== m_len) begin
                    n_errors++; $display("FAIL len: got %0d want %0d (cycle %0d)", len_o, m_len, cyc);
                end
            end
            n_checks++;
            if (m_tvalid_o !== ev || (ev && {m_tlast_o, m_tdata_o} !== {el, ed})) begin
                n_errors++; $display("FAIL m_stream: got v%b l%b d%h want v%b l%b d%h (cycle %0d)",
                                     m_tvalid_o, m_tlast_o, m_tdata_o, ev, el, ed, cyc);
            end
            n_checks++;
            if ({hsk_tready_o, ctl_tready_o, blk_tready_o} !== er) begin
                n_errors++; $display("FAIL treadys: got %b want %b (cycle %0d)",
                                     {hsk_tready_o, ctl_tready_o, blk_tready_o}, er, cyc);
            end
            if (ev && m_tready_i) begin
                n_checks++;
                have = 0; eb = 9'h1ff;
                case (m_grant)
                    2'd1: if (hsk_e.size() != 0) begin eb = hsk_e.pop_front(); have = 1; end
                    2'd2: if (ctl_e.size() != 0) begin eb = ctl_e.pop_front(); have = 1; end
                    2'd3: if (blk_e.size() != 0) begin eb = blk_e.pop_front(); have = 1; end
                    default: ;
                endcase
                if (!have || {m_tlast_o, m_tdata_o} !== eb) begin
                    n_errors++; $display("FAIL beat_data: got %h want %h src %0d (cycle %0d)",
                                         {m_tlast_o, m_tdata_o}, eb, m_grant, cyc);
                end
            end
        end
        if (reset_n && grant_o != 0 && prev_grant == 0) begin
            grant_log.push_back(int'(grant_o)); grant_cyc.push_back(cyc);
        end
        if (reset_n && len_valid_o) len_log.push_back(int'(len_o));
        if (m_tvalid_o && m_tready_i) begin
            beat_cnt++;
            if (m_tlast_o) last_log.push_back(cyc);
        end
        if (prev_busy && !busy_o) busy_fall_cyc = cyc;
        prev_grant = int'(grant_o);
        prev_busy  = busy_o;
        if (hsk_tvalid_i && hsk_tready_o) void'(hsk_q.pop_front());
        if (ctl_tvalid_i && ctl_tready_o) void'(ctl_q.pop_front());
        if (blk_tvalid_i && blk_tready_o) void'(blk_q.pop_front());
        // Advance the reference model by one clock.
        if (!reset_n) begin
            m_grant = 0; m_gap = 0; m_rr = 0; m_cnt = 0; m_lv = 0; m_len = 0;
        end else begin
            m_lv = 0;
            if (m_grant != 0) begin
                if (ev && m_tready_i) begin
                    if (el) begin
                        m_len = (m_cnt + 1 > MAXLEN) ? MAXLEN : m_cnt + 1;
                        m_lv = 1; m_cnt = 0;
                        if (m_grant == 2) m_rr = 1;
                        else if (m_grant == 3) m_rr = 0;
                        m_grant = 0; m_gap = GAP;
                    end else begin
                        m_cnt = (m_cnt + 1 > MAXLEN) ? MAXLEN : m_cnt + 1;
                    end
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (enable_i && (hsk_tvalid_i || ctl_tvalid_i || blk_tvalid_i)) begin
                if (hsk_tvalid_i) m_grant = 1;
                else if (ctl_tvalid_i && blk_tvalid_i) m_grant = m_rr ? 2'd3 : 2'd2;
                else m_grant = ctl_tvalid_i ? 2'd2 : 2'd3;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((hsk_q.size() + ctl_q.size() + blk_q.size() != 0 || m_grant != 0 || m_gap != 0) && n < budget) begin
            step(); n++;
        end
        repeat (2) step();
        n_checks++;
        if (hsk_e.size() + ctl_e.size() + blk_e.size() != 0 || hsk_q.size() + ctl_q.size() + blk_q.size() != 0) begin
            n_errors++; $display("FAIL drain: %0d beats undelivered after %0d cycles", hsk_e.size() + ctl_e.size() + blk_e.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable_i = 1'b1; rdy_mode = 0;
        repeat (3) step();
        reset_n = 1'b1;
        n_checks++;
        if ({grant_o, busy_o, len_valid_o, m_tvalid_o} !== 5'd0 || len_o !== '0) begin
            n_errors++; $display("FAIL reset_state: got g%0d b%b lv%b v%b len%0d want all 0", grant_o, busy_o, len_valid_o, m_tvalid_o, len_o);
        end
        n_checks++;
        if ({hsk_tready_o, ctl_tready_o, blk_tready_o, z_grant_o, z_busy_o} !== 6'd0) begin
            n_errors++; $display("FAIL reset_ready: got %b want 0", {hsk_tready_o, ctl_tready_o, blk_tready_o, z_grant_o, z_busy_o});
        end
    endtask

    task automatic test_priority();
        int eg[3] = '{1, 2, 3};
        int el[3] = '{1, 4, 6};
        clear_logs();
        add_pkt(1, 1, 8'hD2, 0); add_pkt(2, 4, 8'h10, 0); add_pkt(3, 6, 8'h20, 0);
        drain(200);
        n_checks++;
        if (grant_log.size() != 3 || len_log.size() != 3) begin
            n_errors++; $display("FAIL prio_count: got %0d grants %0d lens want 3 3", grant_log.size(), len_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (grant_log[i] != eg[i] || len_log[i] != el[i]) begin
                    n_errors++; $display("FAIL prio_order[%0d]: got g%0d len%0d want g%0d len%0d", i, grant_log[i], len_log[i], eg[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        int vcyc;
        clear_logs();
        add_pkt(2, 8, 8'h80, 0);
        vcyc = cyc + 1;
        drain(200);
        n_checks++;
        if (grant_log.size() != 1 || grant_log[0] != 2 || grant_cyc[0] != vcyc + 1) begin
            n_errors++; $display("FAIL single_grant: got %0d grants (first g%0d at %0d) want g2 at %0d",
                                 grant_log.size(), (grant_log.size() != 0) ? grant_log[0] : 0, (grant_cyc.size() != 0) ? grant_cyc[0] : -1, vcyc + 1);
        end
        n_checks++;
        if (len_log.size() != 1 || len_log[0] != 8) begin
            n_errors++; $display("FAIL single_len: got %0d pulses (first %0d) want one of 8", len_log.size(), (len_log.size() != 0) ? len_log[0] : -1);
        end
        n_checks++;
        if (last_log.size() != 1 || busy_fall_cyc - last_log[0] != GAP + 1) begin
            n_errors++; $display("FAIL single_busy_gap: got %0d want %0d", (last_log.size() != 0) ? busy_fall_cyc - last_log[0] : -1, GAP + 1);
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        rdy_mode = 2; rdy_phase = 0;
        add_pkt(3, 5, 8'h40, 0);
        for (int i = 0; i < 20 && grant_o != 2'd3; i++) step();
        repeat (3) step();
        add_pkt(2, 2, 8'h50, 0);
        drain(300);
        rdy_mode = 0;
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 2) begin
            n_errors++; $display("FAIL bp_order: got %0d grants want 3 then 2", grant_log.size());
        end else begin
            n_checks++;
            if (last_log.size() < 1 || grant_cyc[1] - last_log[0] != GAP + 2) begin
                n_errors++; $display("FAIL bp_gap: got %0d want %0d", (last_log.size() != 0) ? grant_cyc[1] - last_log[0] : -1, GAP + 2);
            end
        end
        n_checks++;
        if (len_log.size() != 2 || len_log[0] != 5 || len_log[1] != 2) begin
            n_errors++; $display("FAIL bp_len: got %0d pulses (first %0d) want 5 then 2", len_log.size(), (len_log.size() != 0) ? len_log[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            add_pkt(2, 3, 8'(8'h60 + 4 * i), 0);
            add_pkt(3, 3, 8'(8'h90 + 4 * i), 0);
        end
        drain(500);
        n_checks++;
        if (grant_log.size() != 8 || grant_log[0] != 3) begin
            n_errors++; $display("FAIL rr_count: got %0d grants (first g%0d) want 8 starting g3",
                                 grant_log.size(), (grant_log.size() != 0) ? grant_log[0] : 0);
        end else begin
            for (int i = 1; i < 8; i++) begin
                n_checks++;
                if (grant_log[i] == grant_log[i - 1] || grant_log[i] < 2) begin
                    n_errors++; $display("FAIL rr_alternate[%0d]: got g%0d after g%0d", i, grant_log[i], grant_log[i - 1]);
                end
            end
        end
    endtask

    task automatic test_enable();
        clear_logs();
        enable_i = 1'b0;
        add_pkt(1, 1, 8'hD2, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (grant_o !== 2'd0) begin
                n_errors++; $display("FAIL enable_hold[%0d]: got g%0d want 0", i, grant_o);
            end
        end
        enable_i = 1'b1;
        step();
        n_checks++;
        if (grant_o !== 2'd1) begin
            n_errors++; $display("FAIL enable_grant: got g%0d want 1", grant_o);
        end
        drain(100);
    endtask

    task automatic test_random();
        int pk = 0;
        clear_logs();
        rdy_mode = 1;
        for (int i = 0; i < 600; i++) begin
            enable_i = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0 && pk < 40) begin
                add_pkt($urandom_range(1, 3), $urandom_range(1, 6), 8'h00, 1);
                pk++;
            end
            step();
        end
        enable_i = 1'b1;
        drain(2000);
        rdy_mode = 0;
        n_checks++;
        if (len_log.size() != pk) begin
            n_errors++; $display("FAIL random_pkts: got %0d completions want %0d", len_log.size(), pk);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        add_pkt(2, 8, 8'hA0, 0);
        beat_cnt = 0;
        for (int i = 0; i < 40 && beat_cnt < 2; i++) step();
        reset_n = 1'b0;
        step();
        n_checks++;
        if ({grant_o, busy_o, len_valid_o, m_tvalid_o} !== 5'd0 || len_o !== '0) begin
            n_errors++; $display("FAIL mid_reset: got g%0d b%b lv%b v%b len%0d want all 0", grant_o, busy_o, len_valid_o, m_tvalid_o, len_o);
        end
        hsk_q.delete(); ctl_q.delete(); blk_q.delete();
        hsk_e.delete(); ctl_e.delete(); blk_e.delete();
        reset_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_gap_zero();
        z_hsk_tvalid_i = 1'b1; z_hsk_tlast_i = 1'b1; z_hsk_tdata_i = 8'hD2;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock); #1;
            n_checks++;
            if (z_grant_o !== 2'(k % 2)) begin
                n_errors++; $display("FAIL gap0_grant[%0d]: got g%0d want %0d", k, z_grant_o, k % 2);
            end
            n_checks++;
            if (z_len_valid_o !== (k >= 2 && k % 2 == 0) || (z_len_valid_o && z_len_o !== 11'd1)) begin
                n_errors++; $display("FAIL gap0_len[%0d]: got lv%b len%0d want lv%b len 1", k, z_len_valid_o, z_len_o, (k >= 2 && k % 2 == 0));
            end
            if (k % 2 == 1) begin
                n_checks++;
                if (z_m_tvalid_o !== 1'b1 || z_m_tdata_o !== 8'hD2 || z_hsk_tready_o !== 1'b1) begin
                    n_errors++; $display("FAIL gap0_beat[%0d]: got v%b d%h r%b want v1 dd2 r1", k, z_m_tvalid_o, z_m_tdata_o, z_hsk_tready_o);
                end
            end
        end
        z_hsk_tvalid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_priority();
        test_single();
        test_backpressure();
        test_round_robin();
        test_enable();
        test_random();
        test_reset_mid();
        test_gap_zero();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
